// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
//
// Round-robin read arbiter that shares one pixel-memory read port among
// NUM_CLIENTS strip drivers. Each client presents a level request plus an
// address and receives a one-cycle data_rdy pulse together with its own
// held data lane. The memory may be asynchronous (MEM_LATENCY = 0) or
// pipelined (MEM_LATENCY cycles from address to data).
//
// A transaction always walks IDLE -> WAIT (MEM_LATENCY+1 cycles) -> RESP,
// so the port serves one read every 3+MEM_LATENCY cycles.
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   rst            synchronous, active-high reset
//   data_req       per-client read request (level, held until data_rdy)
//   data_addr      client i address at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   data           client i read data at [i*DATA_WIDTH +: DATA_WIDTH]
//   data_rdy       one-cycle completion pulse per client (at most one set)
//   mem_data_addr  registered address to memory, holds its value when idle
//   mem_rd_en      high while a read is outstanding
//   mem_data       read data returned by memory
// ---------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int NUM_CLIENTS   = 4,
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_LATENCY   = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CLIENTS-1:0]               data_req,
  input  logic [NUM_CLIENTS*ADDRESS_WIDTH-1:0] data_addr,
  output logic [NUM_CLIENTS*DATA_WIDTH-1:0]    data,
  output logic [NUM_CLIENTS-1:0]               data_rdy,
  output logic [ADDRESS_WIDTH-1:0]             mem_data_addr,
  output logic                                 mem_rd_en,
  input  logic [DATA_WIDTH-1:0]                mem_data
);

  localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int LW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;

  localparam logic [LW-1:0] LAT_INIT    = LW'(MEM_LATENCY);
  localparam logic [PW-1:0] LAST_CLIENT = PW'(NUM_CLIENTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                          state_q;
  logic [PW-1:0]                   rr_ptr_q;
  logic [PW-1:0]                   grant_q;
  logic [PW-1:0]                   grant_d;
  logic                            found_d;
  logic [LW-1:0]                   lat_cnt_q;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] data_q;
  logic [NUM_CLIENTS-1:0]          data_rdy_q;
  logic [ADDRESS_WIDTH-1:0]        mem_addr_q;
  logic                            mem_rd_en_q;
  logic [PW-1:0]                   rr_next;

  // Scan from rr_ptr upwards with wrap-around. The loop runs from the
  // farthest offset down to offset 0 so the closest requester to rr_ptr
  // is the last (and therefore winning) assignment.
  always_comb begin
    int idx;
    grant_d = '0;
    found_d = 1'b0;
    idx     = 0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CLIENTS) begin
        idx = idx - NUM_CLIENTS;
      end
      if (data_req[PW'(idx)]) begin
        grant_d = PW'(idx);
        found_d = 1'b1;
      end
    end
  end

  // Pointer moves just past the client served last, wrapping at the end.
  assign rr_next = (grant_q == LAST_CLIENT) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      lat_cnt_q   <= '0;
      data_q      <= '0;
      data_rdy_q  <= '0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            grant_q     <= grant_d;
            mem_addr_q  <= data_addr[int'(grant_d)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            mem_rd_en_q <= 1'b1;
            lat_cnt_q   <= LAT_INIT;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          // The address stays on the bus while the memory pipeline fills;
          // data is captured once the countdown reaches zero.
          if (lat_cnt_q != '0) begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end else begin
            data_q[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] <= mem_data;
            data_rdy_q[grant_q] <= 1'b1;
            mem_rd_en_q         <= 1'b0;
            state_q             <= RESP;
          end
        end
        RESP: begin
          data_rdy_q <= '0;
          rr_ptr_q   <= rr_next;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data          = data_q;
  assign data_rdy      = data_rdy_q;
  assign mem_data_addr = mem_addr_q;
  assign mem_rd_en     = mem_rd_en_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

  localparam int NK = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       rst_v [NK];
  logic [3:0] req   [NK];
  logic [39:0] addr [NK];
  wire  [31:0] dout [NK];
  wire  [3:0]  rdy  [NK];
  wire  [9:0]  maddr[NK];
  wire         ren  [NK];
  wire  [7:0]  mdata[NK];

  // Memory contents: low address byte plus a scrambled high part.
  function automatic logic [7:0] memf(input logic [9:0] a);
    logic [7:0] hi;
    hi = {6'd0, a[9:8]};
    return a[7:0] + hi * 8'd37;
  endfunction

  function automatic int lat_of(input int k);
    case (k)
      0: return 0;
      1: return 2;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int n_of(input int k);
    return (k == 3) ? 1 : 4;
  endfunction

  // DUT 0: 4 clients async; DUT 1: latency 2; DUT 2: latency 3; DUT 3: one client latency 1
  for (genvar g = 0; g < NK; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 3 : 1;
    localparam int NC  = (g == 3) ? 1 : 4;
    wire [NC*8-1:0] dw;
    wire [NC-1:0]   rw;
    logic [7:0]     pipe [4];

    bus_arbiter_rr #(
      .NUM_CLIENTS(NC), .ADDRESS_WIDTH(10), .DATA_WIDTH(8), .MEM_LATENCY(LAT)
    ) u_dut (
      .clk(clk), .rst(rst_v[g]),
      .data_req(req[g][NC-1:0]), .data_addr(addr[g][NC*10-1:0]),
      .data(dw), .data_rdy(rw),
      .mem_data_addr(maddr[g]), .mem_rd_en(ren[g]), .mem_data(mdata[g])
    );

    assign dout[g] = 32'(dw);
    assign rdy[g]  = 4'(rw);

    always @(posedge clk) begin
      pipe[0] <= ren[g] ? memf(maddr[g]) : 8'hA5;
      for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
    end
    assign mdata[g] = (LAT == 0) ? memf(maddr[g]) : pipe[(LAT == 0) ? 0 : LAT - 1];
  end

  // Transaction-level reference: a read occupies 3+L edges counted from the
  // sampling edge; completion is visible after edge L+1 of that transaction.
  bit         m_busy [NK];
  int         m_ptr  [NK];
  int         m_age  [NK];
  int         m_grant[NK];
  logic [3:0] m_rdy  [NK];
  logic       m_ren  [NK];
  logic [9:0] m_maddr[NK];
  logic [7:0] m_lane [NK][4];

  task automatic tick(input int k);
    int n, lat, g;
    n = n_of(k);
    lat = lat_of(k);
    if (rst_v[k]) begin
      m_busy[k] = 0; m_ptr[k] = 0; m_rdy[k] = 4'd0; m_ren[k] = 1'b0; m_maddr[k] = 10'd0;
      for (int i = 0; i < 4; i++) m_lane[k][i] = 8'd0;
    end else if (!m_busy[k]) begin
      g = -1;
      for (int j = 0; j < n; j++)
        if (g < 0 && req[k][(m_ptr[k] + j) % n]) g = (m_ptr[k] + j) % n;
      if (g >= 0) begin
        m_busy[k] = 1; m_age[k] = 0; m_grant[k] = g; m_ren[k] = 1'b1;
        m_maddr[k] = addr[k][g*10 +: 10];
      end
    end else begin
      m_age[k]++;
      g = m_grant[k];
      if (m_age[k] == lat + 1) begin
        m_lane[k][g] = memf(m_maddr[k]);
        m_rdy[k] = 4'b0001 << g;
        m_ren[k] = 1'b0;
      end else if (m_age[k] == lat + 2) begin
        m_rdy[k] = 4'd0;
        m_ptr[k] = (g + 1) % n;
        m_busy[k] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int k);
    rst_v[k] = 1'b1;
    req[k] = 4'd0;
    tick(k);
    rst_v[k] = 1'b0;
  endtask

  task automatic wait_rdy(input int k, input int maxc, output int cyc, output logic [3:0] seen);
    cyc = -1;
    seen = 4'd0;
    for (int c = 1; c <= maxc; c++) begin
      tick(k);
      if (rdy[k] != 4'd0) begin
        cyc = c;
        seen = rdy[k];
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cyc;
    logic [3:0] seen;
    rst_v[0] = 1'b1;
    req[0] = 4'hF;
    addr[0] = {10'd40, 10'd30, 10'd20, 10'd10};
    for (int c = 0; c < 3; c++) begin
      tick(0);
      checks++; if (rdy[0] !== 4'd0) begin errors++; $display("FAIL reset_rdy: got %b expected 0000", rdy[0]); end
      checks++; if (ren[0] !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", ren[0]); end
      checks++; if (dout[0] !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", dout[0]); end
      checks++; if (maddr[0] !== 10'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", maddr[0]); end
    end
    rst_v[0] = 1'b0;
    wait_rdy(0, 10, cyc, seen);
    checks++; if (seen !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected 0001", seen); end
    checks++; if (cyc != 2) begin errors++; $display("FAIL reset_first_latency: got %0d expected 2", cyc); end
    req[0] = 4'd0;
    repeat (3) tick(0);
  endtask

  task automatic test_single();
    int cyc;
    logic [3:0] seen;
    do_reset(0);
    addr[0][0 +: 10] = 10'd700;
    req[0] = 4'b0001;
    wait_rdy(0, 10, cyc, seen);
    req[0] = 4'd0;
    tick(0);
    tick(0);
    addr[0][20 +: 10] = 10'd5;
    req[0] = 4'b0100;
    wait_rdy(0, 10, cyc, seen);
    req[0] = 4'd0;
    checks++; if (cyc != 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", cyc); end
    checks++; if (seen !== 4'b0100) begin errors++; $display("FAIL single_rdy: got %b expected 0100", seen); end
    checks++; if (dout[0][23:16] !== 8'd5) begin errors++; $display("FAIL single_data2: got %h expected 05", dout[0][23:16]); end
    checks++; if (dout[0][7:0] !== memf(10'd700)) begin errors++; $display("FAIL single_lane0_held: got %h expected %h", dout[0][7:0], memf(10'd700)); end
    checks++; if ({dout[0][31:24], dout[0][15:8]} !== 16'd0) begin errors++; $display("FAIL single_lanes13: got %h expected 0000", {dout[0][31:24], dout[0][15:8]}); end
    tick(0);
    checks++; if (rdy[0] !== 4'd0) begin errors++; $display("FAIL single_pulse_width: got %b expected 0000", rdy[0]); end
  endtask

  task automatic check_order(input logic [3:0] pattern, input int num, input int exp_ord [6], input string nm);
    int cyc, cnt [4];
    logic [3:0] seen;
    do_reset(0);
    for (int i = 0; i < 4; i++) begin addr[0][i*10 +: 10] = 10'(i * 100 + 7); cnt[i] = 0; end
    req[0] = pattern;
    for (int t = 0; t < num; t++) begin
      wait_rdy(0, 10, cyc, seen);
      checks++;
      if (seen !== (4'b0001 << exp_ord[t])) begin
        errors++; $display("FAIL %s_grant%0d: got %b expected client %0d", nm, t, seen, exp_ord[t]);
      end
      if (t > 0) begin
        checks++; if (cyc != 3) begin errors++; $display("FAIL %s_spacing%0d: got %0d expected 3", nm, t, cyc); end
      end
      for (int i = 0; i < 4; i++) if (seen[i]) cnt[i]++;
      checks++;
      if (dout[0][exp_ord[t]*8 +: 8] !== memf(10'(exp_ord[t] * 100 + 7))) begin
        errors++; $display("FAIL %s_data%0d: got %h expected %h", nm, t, dout[0][exp_ord[t]*8 +: 8], memf(10'(exp_ord[t] * 100 + 7)));
      end
    end
    if (pattern == 4'hF) begin
      checks++;
      if (cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 1 || cnt[3] != 1) begin
        errors++; $display("FAIL %s_fairness: got %0d %0d %0d %0d expected 2 2 1 1", nm, cnt[0], cnt[1], cnt[2], cnt[3]);
      end
    end
    req[0] = 4'd0;
    repeat (3) tick(0);
  endtask

  task automatic test_round_robin();
    int o1 [6] = '{0, 1, 2, 3, 0, 1};
    int o2 [6] = '{0, 2, 0, 2, 0, 2};
    int o3 [6] = '{1, 3, 1, 3, 1, 3};
    check_order(4'hF, 6, o1, "rr_all");
    check_order(4'b0101, 4, o2, "rr_skip");
    check_order(4'b1010, 4, o3, "rr_odd");
  endtask

  task automatic test_latency();
    int cyc, en_cnt;
    do_reset(1);
    addr[1][10 +: 10] = 10'd300;
    req[1] = 4'b0010;
    cyc = -1;
    en_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      if (ren[1]) en_cnt++;
      if (cyc < 0 && rdy[1] != 4'd0) begin
        cyc = c;
        req[1] = 4'd0;
        checks++; if (rdy[1] !== 4'b0010) begin errors++; $display("FAIL lat_rdy: got %b expected 0010", rdy[1]); end
      end
    end
    checks++; if (cyc != 4) begin errors++; $display("FAIL lat_cycles: got %0d expected 4", cyc); end
    checks++; if (en_cnt != 3) begin errors++; $display("FAIL lat_rd_en_cycles: got %0d expected 3", en_cnt); end
    checks++; if (dout[1][15:8] !== memf(10'd300)) begin errors++; $display("FAIL lat_data: got %h expected %h", dout[1][15:8], memf(10'd300)); end
  endtask

  task automatic test_reset_mid_wait();
    int cyc, pulses;
    logic [3:0] seen;
    do_reset(2);
    addr[2][30 +: 10] = 10'd123;
    req[2] = 4'b1000;
    tick(2);
    tick(2);
    rst_v[2] = 1'b1;
    req[2] = 4'd0;
    tick(2);
    rst_v[2] = 1'b0;
    checks++; if (ren[2] !== 1'b0) begin errors++; $display("FAIL midwait_rd_en: got %b expected 0", ren[2]); end
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick(2);
      if (rdy[2] != 4'd0) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midwait_no_pulse: got %0d pulses expected 0", pulses); end
    checks++; if (dout[2] !== 32'd0) begin errors++; $display("FAIL midwait_data: got %h expected 0", dout[2]); end
    req[2] = 4'hF;
    wait_rdy(2, 12, cyc, seen);
    req[2] = 4'd0;
    checks++; if (seen !== 4'b0001) begin errors++; $display("FAIL midwait_next_grant: got %b expected 0001", seen); end
    checks++; if (cyc != 5) begin errors++; $display("FAIL midwait_latency: got %0d expected 5", cyc); end
  endtask

  task automatic test_drop();
    int cyc;
    logic [3:0] seen;
    do_reset(0);
    addr[0][10 +: 10] = 10'd513;
    req[0] = 4'b0010;
    tick(0);
    req[0] = 4'd0;
    wait_rdy(0, 8, cyc, seen);
    checks++; if (seen !== 4'b0010 || cyc != 1) begin errors++; $display("FAIL drop_completes: got %b after %0d expected 0010 after 1", seen, cyc); end
    checks++; if (dout[0][15:8] !== memf(10'd513)) begin errors++; $display("FAIL drop_data: got %h expected %h", dout[0][15:8], memf(10'd513)); end
  endtask

  task automatic test_single_client();
    int cyc;
    logic [3:0] seen;
    logic [9:0] a;
    do_reset(3);
    a = 10'd1000;
    addr[3][9:0] = a;
    req[3] = 4'b0001;
    for (int t = 0; t < 4; t++) begin
      wait_rdy(3, 10, cyc, seen);
      checks++; if (seen !== 4'b0001) begin errors++; $display("FAIL one_grant%0d: got %b expected 0001", t, seen); end
      checks++; if (cyc != ((t == 0) ? 3 : 4)) begin errors++; $display("FAIL one_cycles%0d: got %0d expected %0d", t, cyc, (t == 0) ? 3 : 4); end
      checks++; if (dout[3][7:0] !== memf(a)) begin errors++; $display("FAIL one_data%0d: got %h expected %h", t, dout[3][7:0], memf(a)); end
      a = 10'($urandom);
      addr[3][9:0] = a;
    end
    req[3] = 4'd0;
  endtask

  task automatic test_random(input int k, input int ncyc);
    int n;
    n = n_of(k);
    do_reset(k);
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < n; i++) begin
        if (req[k][i]) begin
          if (rdy[k][i]) begin
            if ($urandom_range(1, 0) == 1) addr[k][i*10 +: 10] = 10'($urandom);
            else req[k][i] = 1'b0;
          end
        end else if ($urandom_range(2, 0) == 0) begin
          req[k][i] = 1'b1;
          addr[k][i*10 +: 10] = 10'($urandom);
        end
      end
      rst_v[k] = ($urandom_range(199, 0) == 0);
      tick(k);
      checks++; if (rdy[k] !== m_rdy[k]) begin errors++; $display("FAIL rand%0d_rdy@%0d: got %b expected %b", k, c, rdy[k], m_rdy[k]); end
      checks++; if (ren[k] !== m_ren[k]) begin errors++; $display("FAIL rand%0d_rd_en@%0d: got %b expected %b", k, c, ren[k], m_ren[k]); end
      checks++; if (maddr[k] !== m_maddr[k]) begin errors++; $display("FAIL rand%0d_addr@%0d: got %h expected %h", k, c, maddr[k], m_maddr[k]); end
      checks++; if ($countones(rdy[k]) > 1) begin errors++; $display("FAIL rand%0d_onehot@%0d: got %b expected at most one bit", k, c, rdy[k]); end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (dout[k][i*8 +: 8] !== m_lane[k][i]) begin
          errors++; $display("FAIL rand%0d_lane%0d@%0d: got %h expected %h", k, i, c, dout[k][i*8 +: 8], m_lane[k][i]);
        end
      end
    end
    rst_v[k] = 1'b0;
    req[k] = 4'd0;
  endtask

  initial begin
    for (int k = 0; k < NK; k++) begin
      rst_v[k] = 1'b1;
      req[k] = 4'd0;
      addr[k] = 40'd0;
      m_busy[k] = 0; m_ptr[k] = 0; m_age[k] = 0; m_grant[k] = 0;
      m_rdy[k] = 4'd0; m_ren[k] = 1'b0; m_maddr[k] = 10'd0;
      for (int i = 0; i < 4; i++) m_lane[k][i] = 8'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NK; k++) rst_v[k] = 1'b0;

    test_reset();
    test_single();
    test_round_robin();
    test_latency();
    test_reset_mid_wait();
    test_drop();
    test_single_client();
    for (int k = 0; k < NK; k++) test_random(k, 1500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
